// File: rtl/periph_slave_rr_arbiter_if.sv
// ----------------------------------------------------------------------------
// periph_slave_rr_arbiter_if
// Bundles every bus signal around one peripheral slave port. Signal names are
// written from the arbiter's point of view.
//   PE side    : data_req_i/add_i/wen_i/wdata_i/be_i in,
//                data_gnt_o/r_valid_o/r_rdata_o out
//   slave side : data_req_o/add_o/wen_o/wdata_o/be_o/ID_o out,
//                data_gnt_i/r_valid_i/r_ID_i/r_rdata_i in
//   status     : err_o
// Modport "slave" is the arbiter itself (the slave port of the interconnect).
// Modport "master" is the environment: the PEs and the peripheral together.
// ----------------------------------------------------------------------------
interface periph_slave_rr_arbiter_if #(
  parameter int N_MASTER   = 16,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BE_WIDTH   = DATA_WIDTH / 8
);
  logic [N_MASTER-1:0]                 data_req_i;
  logic [N_MASTER-1:0][ADDR_WIDTH-1:0] data_add_i;
  logic [N_MASTER-1:0]                 data_wen_i;
  logic [N_MASTER-1:0][DATA_WIDTH-1:0] data_wdata_i;
  logic [N_MASTER-1:0][BE_WIDTH-1:0]   data_be_i;
  logic [N_MASTER-1:0]                 data_gnt_o;
  logic [N_MASTER-1:0]                 data_r_valid_o;
  logic [DATA_WIDTH-1:0]               data_r_rdata_o;

  logic                                data_req_o;
  logic [ADDR_WIDTH-1:0]               data_add_o;
  logic                                data_wen_o;
  logic [DATA_WIDTH-1:0]               data_wdata_o;
  logic [BE_WIDTH-1:0]                 data_be_o;
  logic [N_MASTER-1:0]                 data_ID_o;
  logic                                data_gnt_i;
  logic                                data_r_valid_i;
  logic [N_MASTER-1:0]                 data_r_ID_i;
  logic [DATA_WIDTH-1:0]               data_r_rdata_i;

  logic                                err_o;

  modport slave (
    input  data_req_i, data_add_i, data_wen_i, data_wdata_i, data_be_i,
    output data_gnt_o, data_r_valid_o, data_r_rdata_o,
    output data_req_o, data_add_o, data_wen_o, data_wdata_o, data_be_o, data_ID_o,
    input  data_gnt_i, data_r_valid_i, data_r_ID_i, data_r_rdata_i,
    output err_o
  );

  modport master (
    output data_req_i, data_add_i, data_wen_i, data_wdata_i, data_be_i,
    input  data_gnt_o, data_r_valid_o, data_r_rdata_o,
    input  data_req_o, data_add_o, data_wen_o, data_wdata_o, data_be_o, data_ID_o,
    output data_gnt_i, data_r_valid_i, data_r_ID_i, data_r_rdata_i,
    input  err_o
  );
endinterface

// File: rtl/periph_slave_rr_arbiter.sv
// ----------------------------------------------------------------------------
// periph_slave_rr_arbiter
// Round-robin arbiter sharing one peripheral slave port among N_MASTER PE
// request ports. A stalled request stays locked on its master until it is
// granted. Grants are withheld while MAX_OUTSTANDING transactions are still
// waiting for a response. Each request carries a one-hot ID, and the returned
// ID steers the response valid back to the issuing PE.
// Ports:
//   clk    : clock
//   rst_n  : synchronous active-low reset
//   bus_if : periph_slave_rr_arbiter_if.slave (all request/response signals)
// Request/grant and response paths are combinational. Only the arbitration
// state is registered.
// ----------------------------------------------------------------------------
module periph_slave_rr_arbiter #(
  parameter int N_MASTER        = 16,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  periph_slave_rr_arbiter_if.slave       bus_if
);
  localparam int PTR_W = (N_MASTER > 1) ? $clog2(N_MASTER) : 1;

  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [2:0]          out_cnt_q, out_cnt_d;
  logic                lock_q, lock_d;
  logic [PTR_W-1:0]    lock_sel_q, lock_sel_d;
  logic                err_q, err_d;

  logic [PTR_W-1:0]    rr_sel, cand, sel, rr_nxt;
  logic                rr_found, req_exist, allow, req_out, hs;
  logic [N_MASTER-1:0] sel_oh;

  // First requester at or after rr_ptr_q, wrapping modulo N_MASTER.
  always_comb begin
    rr_sel   = '0;
    rr_found = 1'b0;
    cand     = '0;
    for (int k = 0; k < N_MASTER; k++) begin
      cand = PTR_W'((int'(rr_ptr_q) + k) % N_MASTER);
      if (!rr_found && bus_if.data_req_i[cand]) begin
        rr_found = 1'b1;
        rr_sel   = cand;
      end
    end
  end

  // While locked, the selection is frozen. A locked master that drops its
  // request counts as "no requester" for the cycle it is released in.
  assign sel       = lock_q ? lock_sel_q : rr_sel;
  assign req_exist = lock_q ? bus_if.data_req_i[lock_sel_q] : rr_found;
  assign allow     = (out_cnt_q < 3'(MAX_OUTSTANDING));
  assign req_out   = allow & req_exist;
  assign hs        = req_out & bus_if.data_gnt_i;
  assign rr_nxt    = PTR_W'((int'(sel) + 1) % N_MASTER);

  always_comb begin
    sel_oh      = '0;
    sel_oh[sel] = 1'b1;
  end

  assign bus_if.data_req_o     = req_out;
  assign bus_if.data_ID_o      = req_exist ? sel_oh : '0;
  assign bus_if.data_add_o     = req_exist ? bus_if.data_add_i[sel]   : '0;
  assign bus_if.data_wen_o     = req_exist ? bus_if.data_wen_i[sel]   : 1'b0;
  assign bus_if.data_wdata_o   = req_exist ? bus_if.data_wdata_i[sel] : '0;
  assign bus_if.data_be_o      = req_exist ? bus_if.data_be_i[sel]    : '0;
  assign bus_if.data_gnt_o     = hs ? sel_oh : '0;
  assign bus_if.data_r_valid_o = bus_if.data_r_ID_i & {N_MASTER{bus_if.data_r_valid_i}};
  assign bus_if.data_r_rdata_o = bus_if.data_r_rdata_i;
  assign bus_if.err_o          = err_q;

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    out_cnt_d  = out_cnt_q;
    lock_d     = lock_q;
    lock_sel_d = lock_sel_q;
    err_d      = err_q;

    if (hs) begin
      rr_ptr_d = rr_nxt;
      lock_d   = 1'b0;
    end else if (req_out) begin
      lock_d     = 1'b1;
      lock_sel_d = sel;
    end else if (lock_q && !bus_if.data_req_i[lock_sel_q]) begin
      lock_d = 1'b0;
      err_d  = 1'b1;
    end

    // A response in the same cycle as a handshake leaves the count unchanged.
    // A response with nothing outstanding is flagged and the count stays at zero.
    if (hs && !bus_if.data_r_valid_i) begin
      out_cnt_d = out_cnt_q + 3'd1;
    end else if (bus_if.data_r_valid_i && !hs) begin
      if (out_cnt_q != 3'd0) out_cnt_d = out_cnt_q - 3'd1;
      else                   err_d     = 1'b1;
    end

    if (bus_if.data_r_valid_i && !$onehot(bus_if.data_r_ID_i)) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_q   <= '0;
      out_cnt_q  <= '0;
      lock_q     <= 1'b0;
      lock_sel_q <= '0;
      err_q      <= 1'b0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      out_cnt_q  <= out_cnt_d;
      lock_q     <= lock_d;
      lock_sel_q <= lock_sel_d;
      err_q      <= err_d;
    end
  end
endmodule
